dlx_hazard_unit: RTL and testbench

- Consumer end of the main-control signal set for the 5-stage DLX pipeline.
- Takes ID-stage decoded controls (RegWrite, MemRead, Branch*, Jump*) plus register specifiers, and tracks in-flight writers through EX/MEM/WB.
- Drives pipeline stall, flush/bubble and EX-operand forwarding selects.
- Sits between the ID decode and the pipeline registers; the datapath owns the actual pipeline registers and muxes.

---
 rtl/dlx_pipe_pkg.sv | 30 +++
 rtl/dlx_fwd_sel.sv | 34 +++
 rtl/dlx_hazard_unit.sv | 154 +++++++++++++++
 tb/tb_dlx_hazard_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/dlx_pipe_pkg.sv
// dlx_pipe_pkg: shared types and constants for the DLX pipeline hazard logic.
//   fwd_sel_t   - 2-bit EX operand source select (FWD_RF / FWD_WB / FWD_MEM)
//   sb_entry_t  - per-stage scoreboard entry tracking an in-flight instruction
//   REG_ZERO    - hard-wired zero register, never a hazard source
//   LINK_REG    - JAL/JALR destination (the datapath already muxes it onto id_rd)
package dlx_pipe_pkg;

    localparam int unsigned SB_RW = 5;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF  = 2'd0;
    localparam fwd_sel_t FWD_WB  = 2'd1;
    localparam fwd_sel_t FWD_MEM = 2'd2;

    localparam logic [SB_RW-1:0] REG_ZERO = 5'd0;
    localparam logic [SB_RW-1:0] LINK_REG = 5'd31;

    typedef struct packed {
        logic             valid;
        logic [SB_RW-1:0] rd;
        logic             reg_write;
        logic             mem_read;
        logic [SB_RW-1:0] rs1;
        logic [SB_RW-1:0] rs2;
        logic             use_rs1;
        logic             use_rs2;
    } sb_entry_t;

endpackage

// File: rtl/dlx_fwd_sel.sv
// dlx_fwd_sel: EX-stage operand forwarding select for one source operand.
//   ex_rs_i  - source register specifier of the instruction in EX
//   ex_use_i - instruction in EX actually reads that source
//   mem_i    - scoreboard entry of the instruction in MEM
//   wb_i     - scoreboard entry of the instruction in WB
//   sel_o    - FWD_MEM, FWD_WB or FWD_RF; the youngest writer wins
module dlx_fwd_sel
    import dlx_pipe_pkg::*;
(
    input  logic [SB_RW-1:0] ex_rs_i,
    input  logic             ex_use_i,
    input  sb_entry_t        mem_i,
    input  sb_entry_t        wb_i,
    output fwd_sel_t         sel_o
);

    // Source fields travel with the entries but only EX needs them.
    logic unused_fields;
    assign unused_fields = ^{mem_i.rs1, mem_i.rs2, mem_i.use_rs1, mem_i.use_rs2,
                             wb_i.mem_read, wb_i.rs1, wb_i.rs2, wb_i.use_rs1, wb_i.use_rs2};

    always_comb begin
        sel_o = FWD_RF;
        // A load sitting in MEM has no data yet; the load-use stall moves it to WB first.
        if (mem_i.valid && mem_i.reg_write && !mem_i.mem_read && (mem_i.rd != REG_ZERO) &&
            (mem_i.rd == ex_rs_i) && ex_use_i) begin
            sel_o = FWD_MEM;
        end else if (wb_i.valid && wb_i.reg_write && (wb_i.rd != REG_ZERO) &&
                     (wb_i.rd == ex_rs_i)) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/dlx_hazard_unit.sv
// dlx_hazard_unit: stall / flush / forwarding control for the 5-stage DLX pipeline.
// Tracks in-flight writers in an EX/MEM/WB scoreboard fed from the ID-stage controls.
//   clk, reset (sync, active-high)
//   id_*           - ID-stage instruction: valid, sources + use flags, rd, RegWrite, MemRead
//   ex_ctrl_taken  - taken branch / jump resolved in EX this cycle
//   stall_pc, stall_ifid, bubble_idex, flush_ifid - pipeline register controls
//   fwd_a, fwd_b   - EX operand selects (0 regfile, 1 MEM/WB, 2 EX/MEM)
//   perf_stall_cnt, perf_flush_cnt - saturating counters, live only when the
//                    DLX_HAZARD_PERF_EN macro is defined, otherwise tied to 0
module dlx_hazard_unit #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned PERF_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_RegWrite,
    input  logic              id_MemRead,
    input  logic              ex_ctrl_taken,
    output logic              stall_pc,
    output logic              stall_ifid,
    output logic              bubble_idex,
    output logic              flush_ifid,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [PERF_W-1:0] perf_stall_cnt,
    output logic [PERF_W-1:0] perf_flush_cnt
);

    import dlx_pipe_pkg::*;

    sb_entry_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic      load_use;
    fwd_sel_t  fwd_a_sel, fwd_b_sel;

    logic [SB_RW-1:0] id_rs1_w, id_rs2_w, id_rd_w;
    assign id_rs1_w = SB_RW'(id_rs1);
    assign id_rs2_w = SB_RW'(id_rs2);
    assign id_rd_w  = SB_RW'(id_rd);

    always_comb begin
        load_use = id_valid && ex_q.valid && ex_q.mem_read && (ex_q.rd != REG_ZERO) &&
                   ((id_use_rs1 && (id_rs1_w == ex_q.rd)) ||
                    (id_use_rs2 && (id_rs2_w == ex_q.rd)));
    end

    // Flush beats load-use: the ID instruction is on the wrong path anyway, and the
    // PC must be free to take the target.
    always_comb begin
        stall_pc    = 1'b0;
        stall_ifid  = 1'b0;
        bubble_idex = 1'b0;
        flush_ifid  = 1'b0;
        fwd_a       = FWD_RF;
        fwd_b       = FWD_RF;
        if (!reset) begin
            fwd_a = fwd_a_sel;
            fwd_b = fwd_b_sel;
            if (ex_ctrl_taken) begin
                flush_ifid  = 1'b1;
                bubble_idex = 1'b1;
            end else if (load_use) begin
                stall_pc    = 1'b1;
                stall_ifid  = 1'b1;
                bubble_idex = 1'b1;
            end
        end
    end

    always_comb begin
        ex_d = '0;
        if (id_valid && !bubble_idex) begin
            ex_d.valid     = 1'b1;
            ex_d.rd        = id_rd_w;
            ex_d.reg_write = id_RegWrite;
            ex_d.mem_read  = id_MemRead;
            ex_d.rs1       = id_rs1_w;
            ex_d.rs2       = id_rs2_w;
            ex_d.use_rs1   = id_use_rs1;
            ex_d.use_rs2   = id_use_rs2;
        end
        mem_d         = ex_q;
        mem_d.rs1     = '0;
        mem_d.rs2     = '0;
        mem_d.use_rs1 = 1'b0;
        mem_d.use_rs2 = 1'b0;
        wb_d          = mem_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    dlx_fwd_sel u_fwd_a (
        .ex_rs_i  (ex_q.rs1),
        .ex_use_i (ex_q.use_rs1),
        .mem_i    (mem_q),
        .wb_i     (wb_q),
        .sel_o    (fwd_a_sel)
    );

    dlx_fwd_sel u_fwd_b (
        .ex_rs_i  (ex_q.rs2),
        .ex_use_i (ex_q.use_rs2),
        .mem_i    (mem_q),
        .wb_i     (wb_q),
        .sel_o    (fwd_b_sel)
    );

`ifdef DLX_HAZARD_PERF_EN
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (load_use && !ex_ctrl_taken && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + PERF_W'(1);
        end
        if (ex_ctrl_taken && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_dlx_hazard_unit.sv
// tb_dlx_hazard_unit: table-driven directed bench for dlx_hazard_unit.
// Each row is one ID-stage cycle; expected outputs are hand-derived from the
// instruction stream (stalled instructions are re-presented on the next row).
module tb_dlx_hazard_unit;

    localparam int unsigned PERF_W = 32;

    logic              clk;
    logic              reset;
    logic              id_valid;
    logic [4:0]        id_rs1, id_rs2, id_rd;
    logic              id_use_rs1, id_use_rs2;
    logic              id_RegWrite, id_MemRead;
    logic              ex_ctrl_taken;
    logic              stall_pc, stall_ifid, bubble_idex, flush_ifid;
    logic [1:0]        fwd_a, fwd_b;
    logic [PERF_W-1:0] perf_stall_cnt, perf_flush_cnt;

    int n_total = 0;
    int n_pass  = 0;

    dlx_hazard_unit #(
        .REG_AW (5),
        .PERF_W (PERF_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .id_valid       (id_valid),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_use_rs1     (id_use_rs1),
        .id_use_rs2     (id_use_rs2),
        .id_rd          (id_rd),
        .id_RegWrite    (id_RegWrite),
        .id_MemRead     (id_MemRead),
        .ex_ctrl_taken  (ex_ctrl_taken),
        .stall_pc       (stall_pc),
        .stall_ifid     (stall_ifid),
        .bubble_idex    (bubble_idex),
        .flush_ifid     (flush_ifid),
        .fwd_a          (fwd_a),
        .fwd_b          (fwd_b),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } instr_t;

    typedef struct {
        logic       rst;
        instr_t     ins;
        logic       tk;
        logic [7:0] ctl;  // {stall_pc, stall_ifid, bubble_idex, flush_ifid, fwd_a, fwd_b}
        int         ps;   // expected perf_stall_cnt when counters are enabled
        int         pf;   // expected perf_flush_cnt when counters are enabled
    } vec_t;

    function automatic instr_t alu(input logic [4:0] rd, input logic [4:0] rs1,
                                   input logic [4:0] rs2);
        return '{v: 1'b1, rs1: rs1, rs2: rs2, u1: 1'b1, u2: 1'b1, rd: rd, rw: 1'b1, mr: 1'b0};
    endfunction

    function automatic instr_t alui(input logic [4:0] rd, input logic [4:0] rs1);
        return '{v: 1'b1, rs1: rs1, rs2: 5'd0, u1: 1'b1, u2: 1'b0, rd: rd, rw: 1'b1, mr: 1'b0};
    endfunction

    function automatic instr_t ld(input logic [4:0] rd, input logic [4:0] rs1);
        return '{v: 1'b1, rs1: rs1, rs2: 5'd0, u1: 1'b1, u2: 1'b0, rd: rd, rw: 1'b1, mr: 1'b1};
    endfunction

    function automatic instr_t nop();
        return '{v: 1'b0, rs1: 5'd0, rs2: 5'd0, u1: 1'b0, u2: 1'b0, rd: 5'd0, rw: 1'b0,
                 mr: 1'b0};
    endfunction

    function automatic logic [7:0] ctl(input logic s, input logic b, input logic f,
                                       input logic [1:0] fa, input logic [1:0] fb);
        return {s, s, b, f, fa, fb};
    endfunction

    task automatic apply(input vec_t v, input string nm);
        logic [7:0]        got;
        logic [PERF_W-1:0] exp_ps, exp_pf;
        @(negedge clk);
        reset         = v.rst;
        id_valid      = v.ins.v;
        id_rs1        = v.ins.rs1;
        id_rs2        = v.ins.rs2;
        id_use_rs1    = v.ins.u1;
        id_use_rs2    = v.ins.u2;
        id_rd         = v.ins.rd;
        id_RegWrite   = v.ins.rw;
        id_MemRead    = v.ins.mr;
        ex_ctrl_taken = v.tk;
        #1;
        got = {stall_pc, stall_ifid, bubble_idex, flush_ifid, fwd_a, fwd_b};
        n_total++;
        if (got === v.ctl) n_pass++;
        else $display("FAIL %s ctl {stall_pc,stall_ifid,bubble,flush,fwd_a,fwd_b}: got %b want %b",
                      nm, got, v.ctl);
`ifdef DLX_HAZARD_PERF_EN
        exp_ps = PERF_W'(v.ps);
        exp_pf = PERF_W'(v.pf);
`else
        exp_ps = '0;
        exp_pf = '0;
`endif
        n_total++;
        if ({perf_stall_cnt, perf_flush_cnt} === {exp_ps, exp_pf}) n_pass++;
        else $display("FAIL %s perf: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                      nm, perf_stall_cnt, perf_flush_cnt, exp_ps, exp_pf);
    endtask

    vec_t vecs[31];
    vec_t hand[6];

    initial begin
        reset = 1'b1; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0;
        id_use_rs2 = 1'b0; id_rd = '0; id_RegWrite = 1'b0; id_MemRead = 1'b0;
        ex_ctrl_taken = 1'b0;

        // Reset with a taken branch present: reset wins.
        vecs[0]  = '{1'b1, alu(3, 1, 2),  1'b1, ctl(0, 0, 0, 0, 0), 0, 0};
        // ADD r3,r1,r2 ; SUB r4,r3,r5 -> EX/MEM forward on A
        vecs[1]  = '{1'b0, alu(3, 1, 2),  1'b0, ctl(0, 0, 0, 0, 0), 0, 0};
        vecs[2]  = '{1'b0, alu(4, 3, 5),  1'b0, ctl(0, 0, 0, 0, 0), 0, 0};
        vecs[3]  = '{1'b0, nop(),         1'b0, ctl(0, 0, 0, 2, 0), 0, 0};
        // ADD r3 ; NOP ; OR r6,r7,r3 -> MEM/WB forward on B
        vecs[4]  = '{1'b0, alu(3, 1, 2),  1'b0, ctl(0, 0, 0, 0, 0), 0, 0};
        vecs[5]  = '{1'b0, nop(),         1'b0, ctl(0, 0, 0, 0, 0), 0, 0};
        vecs[6]  = '{1'b0, alu(6, 7, 3),  1'b0, ctl(0, 0, 0, 0, 0), 0, 0};
        vecs[7]  = '{1'b0, nop(),         1'b0, ctl(0, 0, 0, 0, 1), 0, 0};
        // ADD r3 ; ADD r3 ; AND r10,r3,r3 -> youngest (EX/MEM) wins on both
        vecs[8]  = '{1'b0, alu(3, 1, 2),  1'b0, ctl(0, 0, 0, 0, 0), 0, 0};
        vecs[9]  = '{1'b0, alu(3, 4, 5),  1'b0, ctl(0, 0, 0, 0, 0), 0, 0};
        vecs[10] = '{1'b0, alu(10, 3, 3), 1'b0, ctl(0, 0, 0, 0, 0), 0, 0};
        vecs[11] = '{1'b0, nop(),         1'b0, ctl(0, 0, 0, 2, 2), 0, 0};
        // LW r8 ; ADD r9,r8,r2 -> one stall, then MEM/WB forward
        vecs[12] = '{1'b0, ld(8, 1),      1'b0, ctl(0, 0, 0, 0, 0), 0, 0};
        vecs[13] = '{1'b0, alu(9, 8, 2),  1'b0, ctl(1, 1, 0, 0, 0), 0, 0};
        vecs[14] = '{1'b0, alu(9, 8, 2),  1'b0, ctl(0, 0, 0, 0, 0), 1, 0};
        vecs[15] = '{1'b0, nop(),         1'b0, ctl(0, 0, 0, 1, 0), 1, 0};
        // r0 destinations never stall or forward
        vecs[16] = '{1'b0, ld(0, 1),      1'b0, ctl(0, 0, 0, 0, 0), 1, 0};
        vecs[17] = '{1'b0, alu(5, 0, 0),  1'b0, ctl(0, 0, 0, 0, 0), 1, 0};
        vecs[18] = '{1'b0, alui(0, 1),    1'b0, ctl(0, 0, 0, 0, 0), 1, 0};
        vecs[19] = '{1'b0, alu(6, 0, 0),  1'b0, ctl(0, 0, 0, 0, 0), 1, 0};
        vecs[20] = '{1'b0, nop(),         1'b0, ctl(0, 0, 0, 0, 0), 1, 0};
        // Flush coincident with a load-use hazard: flush wins
        vecs[21] = '{1'b0, ld(8, 1),      1'b0, ctl(0, 0, 0, 0, 0), 1, 0};
        vecs[22] = '{1'b0, alu(9, 8, 2),  1'b1, ctl(0, 1, 1, 0, 0), 1, 0};
        vecs[23] = '{1'b0, nop(),         1'b0, ctl(0, 0, 0, 0, 0), 1, 1};
        // Reset during a load-use stall, then no stale forwarding afterwards
        vecs[24] = '{1'b0, alu(3, 1, 2),  1'b0, ctl(0, 0, 0, 0, 0), 1, 1};
        vecs[25] = '{1'b0, ld(8, 1),      1'b0, ctl(0, 0, 0, 0, 0), 1, 1};
        vecs[26] = '{1'b1, alu(9, 8, 2),  1'b0, ctl(0, 0, 0, 0, 0), 1, 1};
        vecs[27] = '{1'b0, alu(7, 3, 8),  1'b0, ctl(0, 0, 0, 0, 0), 0, 0};
        vecs[28] = '{1'b0, alu(3, 1, 2),  1'b0, ctl(0, 0, 0, 0, 0), 0, 0};
        vecs[29] = '{1'b0, alu(4, 3, 5),  1'b0, ctl(0, 0, 0, 0, 0), 0, 0};
        vecs[30] = '{1'b0, nop(),         1'b0, ctl(0, 0, 0, 2, 0), 0, 0};

        // Chained loads: LW r8 ; LW r9,0(r8) ; ADD r10,r9,r9 -> two separate one-cycle stalls
        hand[0] = '{1'b0, ld(8, 1),       1'b0, ctl(0, 0, 0, 0, 0), 0, 0};
        hand[1] = '{1'b0, ld(9, 8),       1'b0, ctl(1, 1, 0, 0, 0), 0, 0};
        hand[2] = '{1'b0, ld(9, 8),       1'b0, ctl(0, 0, 0, 0, 0), 1, 0};
        hand[3] = '{1'b0, alu(10, 9, 9),  1'b0, ctl(1, 1, 0, 1, 0), 1, 0};
        hand[4] = '{1'b0, alu(10, 9, 9),  1'b0, ctl(0, 0, 0, 0, 0), 2, 0};
        hand[5] = '{1'b0, nop(),          1'b0, ctl(0, 0, 0, 1, 1), 2, 0};

        repeat (2) @(posedge clk);

        for (int i = 0; i < 31; i++) begin
            apply(vecs[i], $sformatf("row%0d", i));
        end
        for (int i = 0; i < 6; i++) begin
            apply(hand[i], $sformatf("chain%0d", i));
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
